// File: rtl/free_list_pkg.sv
// Shared types and sizing for the rename free list.
// Tags, pointers and the ROB<->FL bundles live here.
package free_list_pkg;

  localparam int NUM_SUPER = 2;
  localparam int NUM_PR    = 64;
  localparam int NUM_FL    = NUM_PR - 32;
  localparam int NUM_ROB   = 32;

  localparam int AR_W  = 5;
  localparam int PR_W  = $clog2(NUM_PR);
  localparam int ROB_W = $clog2(NUM_ROB);
  localparam int IDX_W = $clog2(NUM_FL);
  localparam int PTR_W = IDX_W + 1;

  typedef logic [AR_W-1:0]  ar_t;
  typedef logic [PR_W-1:0]  pr_t;
  typedef logic [ROB_W-1:0] rob_t;
  typedef logic [PTR_W-1:0] ptr_t;

  localparam ar_t  ZERO_REG  = ar_t'(31);
  localparam pr_t  ZERO_PR   = pr_t'(31);
  localparam ptr_t SUPER_CNT = ptr_t'(NUM_SUPER);

  typedef struct packed {
    logic [NUM_SUPER-1:0] retire_en;
    ar_t [NUM_SUPER-1:0]  dest_idx;
    pr_t [NUM_SUPER-1:0]  Told_idx;
  } ROB_FL_OUT_t;

  typedef struct packed {
    logic                FL_valid;
    pr_t [NUM_SUPER-1:0] T_idx;
  } FL_ROB_OUT_t;

  function automatic ptr_t ptr_add(ptr_t p, logic b);
    return p + ptr_t'(b);
  endfunction

endpackage

// File: rtl/free_list_if.sv
// Dispatch / retire / rollback bundle between the
// rename stage (master) and the free list (slave).
interface free_list_if;
  import free_list_pkg::*;

  logic                 dispatch_en;
  ar_t [NUM_SUPER-1:0]  dispatch_dest_idx;
  rob_t [NUM_SUPER-1:0] ROB_idx;
  logic [NUM_SUPER-1:0] retire_en;
  ar_t [NUM_SUPER-1:0]  retire_dest_idx;
  pr_t [NUM_SUPER-1:0]  Told_idx;
  logic                 rollback_en;
  rob_t                 ROB_rollback_idx;
  logic                 FL_valid;
  pr_t [NUM_SUPER-1:0]  T_idx;

  modport master (
    output dispatch_en, dispatch_dest_idx, ROB_idx,
    output retire_en, retire_dest_idx, Told_idx,
    output rollback_en, ROB_rollback_idx,
    input  FL_valid, T_idx
  );

  modport slave (
    input  dispatch_en, dispatch_dest_idx, ROB_idx,
    input  retire_en, retire_dest_idx, Told_idx,
    input  rollback_en, ROB_rollback_idx,
    output FL_valid, T_idx
  );

endinterface

// File: rtl/free_list_checkpoint.sv
// Per-ROB-entry snapshot of the free-list head pointer.
// Later write ports win when two slots hit the same entry.
module fl_checkpoint
  import free_list_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_SUPER-1:0] we,
  input  rob_t [NUM_SUPER-1:0] waddr,
  input  ptr_t [NUM_SUPER-1:0] wdata,
  input  rob_t                 raddr,
  output ptr_t                 rdata
);

  ptr_t cp_q [NUM_ROB];
  ptr_t cp_d [NUM_ROB];

  always_comb begin
    cp_d = cp_q;
    for (int i = 0; i < NUM_SUPER; i++) begin
      if (we[i]) cp_d[waddr[i]] = wdata[i];
    end
  end

  assign rdata = cp_q[raddr];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ROB; i++) cp_q[i] <= '0;
    end else begin
      cp_q <= cp_d;
    end
  end

endmodule

// File: rtl/free_list.sv
// Circular free list of physical tags with combinational
// allocation, in-order refill on retire and ROB checkpoints.
module free_list
  import free_list_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  free_list_if.slave fl_if
);

  pr_t  fl_q [NUM_FL];
  pr_t  fl_d [NUM_FL];
  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  ptr_t count;
  ptr_t cp_rd;
  ptr_t [NUM_SUPER-1:0] post;
  logic [NUM_SUPER-1:0] nz;
  logic [NUM_SUPER-1:0] push;
  logic [NUM_SUPER-1:0] cp_we;
  logic [PTR_W:0]       npush;
  logic                 accept;
  logic                 overflow;

  ROB_FL_OUT_t rob_in;
  FL_ROB_OUT_t fl_out;

  assign rob_in = '{
    retire_en: fl_if.retire_en,
    dest_idx:  fl_if.retire_dest_idx,
    Told_idx:  fl_if.Told_idx
  };

  assign count = tail_q - head_q;

  // Zero-reg dests take ZERO_PR and do not consume a slot.
  always_comb begin
    ptr_t off;
    fl_out = '0;
    fl_out.FL_valid = (count >= SUPER_CNT)
                   && !fl_if.rollback_en;
    off = head_q;
    for (int i = 0; i < NUM_SUPER; i++) begin
      nz[i] = fl_if.dispatch_dest_idx[i] != ZERO_REG;
      fl_out.T_idx[i] = nz[i] ? fl_q[off[IDX_W-1:0]]
                              : ZERO_PR;
      off = ptr_add(off, nz[i]);
      post[i] = off;
    end
  end

  assign accept = en && fl_if.dispatch_en
               && fl_out.FL_valid;
  assign cp_we  = {NUM_SUPER{accept}};

  always_comb begin
    head_d = head_q;
    if (en && fl_if.rollback_en) head_d = cp_rd;
    else if (accept) head_d = post[NUM_SUPER-1];
  end

  always_comb begin
    ptr_t wp;
    fl_d  = fl_q;
    npush = '0;
    wp    = tail_q;
    for (int i = 0; i < NUM_SUPER; i++) begin
      push[i] = en && rob_in.retire_en[i]
             && (rob_in.dest_idx[i] != ZERO_REG);
      if (push[i]) fl_d[wp[IDX_W-1:0]] = rob_in.Told_idx[i];
      wp    = ptr_add(wp, push[i]);
      npush = npush + (PTR_W+1)'(push[i]);
    end
    tail_d = wp;
  end

  assign overflow = ({1'b0, count} + npush)
                  > (PTR_W+1)'(NUM_FL);

  fl_checkpoint u_cp (
    .clock (clock),
    .reset (reset),
    .we    (cp_we),
    .waddr (fl_if.ROB_idx),
    .wdata (post),
    .raddr (fl_if.ROB_rollback_idx),
    .rdata (cp_rd)
  );

  assign fl_if.FL_valid = fl_out.FL_valid;
  assign fl_if.T_idx    = fl_out.T_idx;

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= {1'b1, {IDX_W{1'b0}}};
      for (int i = 0; i < NUM_FL; i++)
        fl_q[i] <= pr_t'(NUM_PR - NUM_FL + i);
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      fl_q   <= fl_d;
    end
  end

  a_no_overflow: assert property (
    @(posedge clock) disable iff (reset) !overflow
  );

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list with a queue-based model
// checked every cycle plus hand-computed tag expectations.
module tb_free_list;
  import free_list_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic en    = 1'b0;

  free_list_if fl_if();

  free_list dut (
    .clock (clock),
    .reset (reset),
    .en    (en),
    .fl_if (fl_if.slave)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  int fq[$];
  int hist[$];
  int cp_tot[NUM_ROB];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    fq.delete();
    hist.delete();
    for (int i = 0; i < NUM_FL; i++) fq.push_back(32 + i);
    for (int i = 0; i < NUM_ROB; i++) cp_tot[i] = 0;
  endfunction

  // Model: free tags as a FIFO, allocations as a history
  // log, checkpoints as allocation counts.
  always @(posedge clock) begin
    int n;
    bit v;
    if (reset) begin
      model_reset();
    end else if (en) begin
      v = (fq.size() >= 2) && !fl_if.rollback_en;
      if (fl_if.rollback_en) begin
        n = hist.size() - cp_tot[fl_if.ROB_rollback_idx];
        for (int k = 0; k < n; k++) fq.push_front(hist.pop_back());
      end else if (fl_if.dispatch_en && v) begin
        for (int i = 0; i < NUM_SUPER; i++) begin
          if (fl_if.dispatch_dest_idx[i] != 5'd31)
            hist.push_back(fq.pop_front());
          cp_tot[fl_if.ROB_idx[i]] = hist.size();
        end
      end
      for (int i = 0; i < NUM_SUPER; i++)
        if (fl_if.retire_en[i] && fl_if.retire_dest_idx[i] != 5'd31)
          fq.push_back(int'(fl_if.Told_idx[i]));
    end
  end

  always @(negedge clock) begin
    int e0, e1;
    bit ev;
    if (!reset) begin
      ev = (fq.size() >= 2) && !fl_if.rollback_en;
      chk("fl_valid", int'(fl_if.FL_valid), int'(ev));
      if (ev) begin
        e0 = (fl_if.dispatch_dest_idx[0] == 5'd31) ? 31 : fq[0];
        e1 = (fl_if.dispatch_dest_idx[1] == 5'd31) ? 31 :
             fq[(fl_if.dispatch_dest_idx[0] == 5'd31) ? 0 : 1];
        chk("t_idx0", int'(fl_if.T_idx[0]), e0);
        chk("t_idx1", int'(fl_if.T_idx[1]), e1);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    fl_if.dispatch_en       = 1'b0;
    fl_if.dispatch_dest_idx = '0;
    fl_if.ROB_idx           = '0;
    fl_if.retire_en         = '0;
    fl_if.retire_dest_idx   = '0;
    fl_if.Told_idx          = '0;
    fl_if.rollback_en       = 1'b0;
    fl_if.ROB_rollback_idx  = '0;
  endtask

  task automatic setin(bit de, int d0, int d1, int r0, int r1);
    fl_if.dispatch_en          = de;
    fl_if.dispatch_dest_idx[0] = 5'(d0);
    fl_if.dispatch_dest_idx[1] = 5'(d1);
    fl_if.ROB_idx[0]           = 5'(r0);
    fl_if.ROB_idx[1]           = 5'(r1);
  endtask

  task automatic retire(int d0, int d1, int t0, int t1);
    fl_if.retire_en          = 2'b11;
    fl_if.retire_dest_idx[0] = 5'(d0);
    fl_if.retire_dest_idx[1] = 5'(d1);
    fl_if.Told_idx[0]        = 6'(t0);
    fl_if.Told_idx[1]        = 6'(t1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic lit(string n, int v, int t0, int t1);
    #1;
    chk({n, "_valid"}, int'(fl_if.FL_valid), v);
    if (v != 0) begin
      chk({n, "_t0"}, int'(fl_if.T_idx[0]), t0);
      chk({n, "_t1"}, int'(fl_if.T_idx[1]), t1);
    end
  endtask

  initial begin
    clr();
    do_reset();
    en = 1'b1;

    setin(1, 1, 2, 0, 1);  lit("rst", 1, 32, 33); tick();
    setin(1, 31, 5, 2, 3); lit("zero0", 1, 31, 34); tick();
    setin(1, 1, 2, 4, 5);  lit("head3", 1, 35, 36); tick();
    en = 1'b0;
    setin(1, 1, 2, 6, 7);  tick();
    en = 1'b1;
    lit("hold", 1, 37, 38); tick();

    // Drain to empty, refill by retire.
    do_reset();
    for (int k = 0; k < 15; k++) begin
      setin(1, 1, 2, (2*k) % 32, (2*k+1) % 32);
      tick();
    end
    setin(1, 3, 4, 30, 31); lit("cnt2", 1, 62, 63); tick();
    setin(1, 1, 2, 0, 1);   lit("empty", 0, 0, 0); tick();
    clr();
    retire(3, 4, 10, 11);   tick();
    clr();
    setin(1, 1, 2, 2, 3);   lit("refill", 1, 10, 11); tick();

    // Rollback to ROB 4.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      setin(1, 1, 2, 4 + 2*k, 5 + 2*k);
      tick();
    end
    setin(1, 1, 2, 12, 13);
    fl_if.rollback_en      = 1'b1;
    fl_if.ROB_rollback_idx = 5'd4;
    lit("rb_busy", 0, 0, 0); tick();
    clr();
    setin(1, 1, 2, 12, 13); lit("rb_head", 1, 33, 34); tick();

    // Reset wins over an in-flight rollback.
    fl_if.rollback_en      = 1'b1;
    fl_if.ROB_rollback_idx = 5'd4;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clr();
    setin(1, 1, 2, 0, 1);  lit("rst_rb", 1, 32, 33); tick();

    // Rollback with simultaneous dual retire, then wrap.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      setin(1, 1, 2, 4 + 2*k, 5 + 2*k);
      tick();
    end
    clr();
    retire(1, 2, 40, 41);
    fl_if.rollback_en      = 1'b1;
    fl_if.ROB_rollback_idx = 5'd6;
    lit("rb_ret", 0, 0, 0); tick();
    clr();
    setin(1, 1, 2, 20, 21); lit("rb_ret_h", 1, 35, 36); tick();
    for (int k = 0; k < 13; k++) begin
      setin(1, 1, 2, 22, 23);
      tick();
    end
    setin(1, 1, 2, 0, 1);   lit("wrap", 1, 63, 40); tick();
    setin(1, 1, 2, 2, 3);   lit("cnt1", 0, 0, 0); tick();
    setin(1, 31, 3, 2, 3);  lit("cnt1z", 0, 0, 0); tick();
    clr();
    retire(7, 8, 50, 51);   tick();
    clr();
    setin(1, 5, 6, 4, 5);   lit("post_wrap", 1, 41, 50); tick();

    // Steady churn so both pointers wrap repeatedly.
    for (int k = 0; k < 40; k++) begin
      clr();
      setin(1, (k % 3 == 0) ? 31 : 1, 2, (2*k) % 32, (2*k+1) % 32);
      retire((k % 5 == 0) ? 31 : 3, 4, (2*k) % 64, (2*k+1) % 64);
      tick();
    end
    clr();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
